// File: rtl/half_adder.sv
// Bitwise half adder with a zero-latency combinational result and a
// one-cycle registered copy qualified by a valid flag.
module half_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] cout_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] cout_d;
  logic             valid_d;
  logic             valid_q;

  // Lanes are independent: no carry crosses from lane i to lane i+1.
  assign sum  = A ^ B;
  assign cout = A & B;

  // Valid semantics: in_valid=1 on a rising edge captures A/B. out_valid is
  // high for exactly the following cycle. There is no backpressure.
  // When in_valid=0 the data registers hold and out_valid drops.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d  = A ^ B;
      cout_d = A & B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: a 1-lane instance and a 4-lane instance
// share the clock and reset.
module tb_half_adder;

  logic       clk;
  logic       rst_n;

  logic [0:0] a1, b1, sum1, cout1, sum_q1, cout_q1;
  logic       v1, ov1;

  logic [3:0] a4, b4, sum4, cout4, sum_q4, cout_q4;
  logic       v4, ov4;

  int checks;
  int failures;

  half_adder #(.WIDTH(1)) u_ha1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .in_valid(v1),
    .sum(sum1), .cout(cout1), .sum_q(sum_q1), .cout_q(cout_q1),
    .out_valid(ov1)
  );

  half_adder #(.WIDTH(4)) u_ha4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .in_valid(v4),
    .sum(sum4), .cout(cout4), .sum_q(sum_q4), .cout_q(cout_q4),
    .out_valid(ov4)
  );

  // Clock: period 10, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reg1(input string tag, input logic [1:0] exp_cs,
                            input logic exp_ov);
    check({tag, "_cs_q"}, {6'd0, cout_q1, sum_q1}, {6'd0, exp_cs});
    check({tag, "_ov"},   {7'd0, ov1},             {7'd0, exp_ov});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; v4 = 1'b0;

    #1;
    check_reg1("reset_state", 2'b00, 1'b0);
    check("reset_state4_sum_q", {4'd0, sum_q4}, 8'h00);

    // Combinational sweep while reset is held: {cout,sum}
    a1 = 1'b0; b1 = 1'b0; #5;
    check("comb_00", {6'd0, cout1, sum1}, 8'h00);
    a1 = 1'b0; b1 = 1'b1; #5;
    check("comb_01", {6'd0, cout1, sum1}, 8'h01);
    a1 = 1'b1; b1 = 1'b0; #5;
    check("comb_10", {6'd0, cout1, sum1}, 8'h01);
    a1 = 1'b1; b1 = 1'b1; #5;
    check("comb_11", {6'd0, cout1, sum1}, 8'h02);

    // No capture while in reset even with in_valid=1
    v1 = 1'b1;
    @(posedge clk); #1;
    check("rst_comb_11", {6'd0, cout1, sum1}, 8'h02);
    check_reg1("rst_no_capture", 2'b00, 1'b0);

    // Release, capture A=1,B=0
    @(negedge clk);
    rst_n = 1'b1; v1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    check_reg1("cap_10", 2'b01, 1'b1);

    // in_valid=0: hold data, drop valid, despite changed inputs
    @(negedge clk);
    v1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
    @(posedge clk); #1;
    check_reg1("hold", 2'b01, 1'b0);

    // Back-to-back captures
    @(negedge clk); v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    @(posedge clk); #1;
    check_reg1("b2b_11", 2'b10, 1'b1);
    @(negedge clk); a1 = 1'b0; b1 = 1'b1;
    @(posedge clk); #1;
    check_reg1("b2b_01", 2'b01, 1'b1);
    @(negedge clk); a1 = 1'b0; b1 = 1'b0;
    @(posedge clk); #1;
    check_reg1("b2b_00", 2'b00, 1'b1);

    // 4-lane: no carry between lanes
    @(negedge clk);
    v1 = 1'b0;
    a4 = 4'b1100; b4 = 4'b1010; v4 = 1'b1;
    #1;
    check("w4_sum",  {4'd0, sum4},  8'h06);
    check("w4_cout", {4'd0, cout4}, 8'h08);
    a4 = 4'b1111; b4 = 4'b0001; #1;
    check("w4_sum_b",  {4'd0, sum4},  8'h0E);
    check("w4_cout_b", {4'd0, cout4}, 8'h01);
    a4 = 4'b1100; b4 = 4'b1010;
    @(posedge clk); #1;
    check("w4_sum_q",  {4'd0, sum_q4},  8'h06);
    check("w4_cout_q", {4'd0, cout_q4}, 8'h08);
    check("w4_ov",     {7'd0, ov4},     8'h01);
    @(negedge clk); v4 = 1'b0;

    // Capture A=1,B=1 then assert reset between edges
    @(negedge clk); v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    @(posedge clk); #1;
    check_reg1("pre_async", 2'b10, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reg1("async_rst", 2'b00, 1'b0);
    check("async_rst_sum_q4", {4'd0, sum_q4}, 8'h00);
    check("async_rst_comb", {6'd0, cout1, sum1}, 8'h02);

    // Release and resume
    @(negedge clk); rst_n = 1'b1; a1 = 1'b0; b1 = 1'b1;
    @(posedge clk); #1;
    check_reg1("post_rst_cap", 2'b01, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Bitwise half adder: each bit lane computes sum = A XOR B and carry = A AND B.
- Combinational outputs (sum, cout) are the primary, zero-latency function and are used directly by upstream arithmetic (full adders, incrementers, ripple chains).
- A registered copy of the result (sum_q, cout_q) with a valid flag is also provided for pipelined consumers on the single system clock.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (>=1); lane i uses A[i], B[i] only, no carry between lanes.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A, one bit per lane.
- B  input  WIDTH  operand B, one bit per lane.
- in_valid  input  1  qualifies A/B for capture into the registered stage; tie high if unused.
- sum  output  WIDTH  combinational sum, A XOR B per lane.
- cout  output  WIDTH  combinational carry-out, A AND B per lane.
- sum_q  output  WIDTH  registered sum, captured when in_valid=1.
- cout_q  output  WIDTH  registered carry, captured when in_valid=1.
- out_valid  output  1  high for exactly the cycle after a cycle with in_valid=1.

Behaviour:
- Combinational path:
  - sum[i] = A[i] ^ B[i]; cout[i] = A[i] & B[i] for every i.
  - Zero latency; no dependence on clk or rst_n. Outputs stay valid while reset is asserted.
  - Truth table per lane (A,B -> sum,cout): 00->00, 01->10, 10->10, 11->01.
  - Invariant per lane: {cout[i],sum[i]} == A[i]+B[i] (2-bit result, never exceeds 2).
  - sum and cout are never both 1 in the same lane.
- Registered path:
  - On posedge clk with in_valid=1: sum_q <= A^B, cout_q <= A&B, out_valid <= 1.
  - On posedge clk with in_valid=0: sum_q/cout_q hold their previous values, out_valid <= 0.
  - Latency: exactly 1 cycle from the capture edge to the registered outputs.
  - Back-to-back in_valid=1 gives one result per cycle (full throughput, no stall, no backpressure).
- Reset:
  - rst_n low asynchronously forces sum_q=0, cout_q=0, out_valid=0, independent of clk.
  - Release is synchronous-safe: registers resume on the first rising clk edge with rst_n high.
  - Assertion mid-stream discards the in-flight result; no capture occurs while rst_n=0.
- X/unknown inputs propagate only to the affected lanes; no cross-lane interaction.
- No internal state other than the WIDTH*2+1 output registers.

Test Plan:
- WIDTH=1, combinational sweep: A,B = 0,0 / 0,1 / 1,0 / 1,1, holding each 5 time units with no clock -> sum,cout = 0,0 / 1,0 / 1,0 / 0,1.
- WIDTH=1, rst_n=0 with A=1,B=1 -> sum=0, cout=1 immediately; sum_q=0, cout_q=0, out_valid=0 throughout reset.
- Registered path, rst_n=1, in_valid=1, A=1,B=0 at edge N -> after edge N: sum_q=1, cout_q=0, out_valid=1. Then in_valid=0 at edge N+1 -> sum_q=1 held, out_valid=0.
- Back-to-back in_valid=1 with (A,B) = (1,1),(0,1),(0,0) on consecutive edges -> (cout_q,sum_q) = 10, 01, 00 on consecutive cycles, out_valid=1 for all three.
- WIDTH=4, A=4'b1100, B=4'b1010 -> sum=4'b0110, cout=4'b1000, with no carry propagation between lanes.
- Asynchronous reset asserted between clock edges after a capture of A=1,B=1 -> cout_q, sum_q and out_valid drop to 0 immediately, without waiting for a clk edge.
